// File: rtl/rx_timer_pkg.sv
// Shared types and default widths for the receiver bit/packet timer.
package rx_timer_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_BIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIRST = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } timer_state_e;

endpackage

// File: rtl/sync_flex_counter.sv
// Enabled up-counter that wraps to zero on the enabled cycle in which it
// equals rollover_val; rollover_flag marks that wrap point combinationally.
module sync_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  // Count register; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_out <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_out <= {WIDTH{1'b0}};
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_out <= {WIDTH{1'b0}};
      end else begin
        count_out <= count_out + WIDTH'(1'b1);
      end
    end else begin
      count_out <= count_out;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// Bit/packet timer: mid-bit first strobe, periodic shift strobes, packet-done
// pulse; supports pause via enable_timer and synchronous abort.
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int BIT_W = DEF_BIT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable_timer,
  input  logic             abort,
  input  logic [CNT_W-1:0] bit_period,
  input  logic [CNT_W-1:0] first_offset,
  input  logic [BIT_W-1:0] packet_bits,
  output logic             shift_strobe,
  output logic             packet_done,
  output logic             busy,
  output logic [BIT_W-1:0] bit_count
);

  timer_state_e     state_r;
  logic [CNT_W-1:0] first_m1_r;
  logic [CNT_W-1:0] period_m1_r;
  logic [BIT_W-1:0] bits_m1_r;
  logic             last_r;
  logic             shift_strobe_r;
  logic             packet_done_r;
  logic             busy_r;
  logic [BIT_W-1:0] bit_count_r;

  logic             start_s;
  logic             per_en_s;
  logic             cnt_clr_s;
  logic             per_flag_s;
  logic             per_hit_s;
  logic             bit_flag_s;
  logic [CNT_W-1:0] per_roll_s;
  logic [BIT_W-1:0] bit_roll_s;
  logic [CNT_W-1:0] per_cnt_unused_s;
  logic [BIT_W-1:0] bit_cnt_s;

  // Targets are stored minus one, with a programmed 0 behaving like 1.
  function automatic logic [CNT_W-1:0] cnt_m1(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return v - CNT_W'(1'b1);
    end
  endfunction

  function automatic logic [BIT_W-1:0] bit_m1(input logic [BIT_W-1:0] v);
    if (v == {BIT_W{1'b0}}) begin
      return {BIT_W{1'b0}};
    end else begin
      return v - BIT_W'(1'b1);
    end
  endfunction

  // Counter controls; in IDLE the live inputs are used so cycle 0 already counts.
  always_comb begin
    start_s    = (state_r == IDLE) & enable_timer & ~abort;
    per_en_s   = 1'b0;
    cnt_clr_s  = 1'b1;
    per_roll_s = period_m1_r;
    bit_roll_s = bits_m1_r;
    case (state_r)
      IDLE: begin
        per_roll_s = cnt_m1(first_offset);
        bit_roll_s = bit_m1(packet_bits);
        per_en_s   = start_s;
        cnt_clr_s  = ~start_s;
      end
      FIRST: begin
        per_roll_s = first_m1_r;
        per_en_s   = enable_timer & ~last_r & ~abort;
        cnt_clr_s  = abort;
      end
      RUN: begin
        per_roll_s = period_m1_r;
        per_en_s   = enable_timer & ~last_r & ~abort;
        cnt_clr_s  = abort;
      end
      DONE: begin
        per_en_s  = 1'b0;
        cnt_clr_s = 1'b1;
      end
      default: begin
        per_en_s  = 1'b0;
        cnt_clr_s = 1'b1;
      end
    endcase
    per_hit_s = per_en_s & per_flag_s;
  end

  sync_flex_counter #(.WIDTH(CNT_W)) u_period_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clr_s),
    .count_enable  (per_en_s),
    .rollover_val  (per_roll_s),
    .count_out     (per_cnt_unused_s),
    .rollover_flag (per_flag_s)
  );

  // Wraps on the final strobe, so its flag flags the strobe that ends the packet.
  sync_flex_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clr_s),
    .count_enable  (per_hit_s),
    .rollover_val  (bit_roll_s),
    .count_out     (bit_cnt_s),
    .rollover_flag (bit_flag_s)
  );

  // Packet FSM with registered outputs; last_r marks a visible final strobe.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      first_m1_r     <= {CNT_W{1'b0}};
      period_m1_r    <= {CNT_W{1'b0}};
      bits_m1_r      <= {BIT_W{1'b0}};
      last_r         <= 1'b0;
      shift_strobe_r <= 1'b0;
      packet_done_r  <= 1'b0;
      busy_r         <= 1'b0;
      bit_count_r    <= {BIT_W{1'b0}};
    end else if (abort) begin
      state_r        <= IDLE;
      last_r         <= 1'b0;
      shift_strobe_r <= 1'b0;
      packet_done_r  <= 1'b0;
      busy_r         <= 1'b0;
      bit_count_r    <= {BIT_W{1'b0}};
    end else begin
      shift_strobe_r <= per_hit_s;
      packet_done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            first_m1_r  <= cnt_m1(first_offset);
            period_m1_r <= cnt_m1(bit_period);
            bits_m1_r   <= bit_m1(packet_bits);
            busy_r      <= 1'b1;
            last_r      <= per_hit_s & bit_flag_s;
            state_r     <= per_hit_s ? RUN : FIRST;
            bit_count_r <= per_hit_s ? (bit_cnt_s + BIT_W'(1'b1)) : {BIT_W{1'b0}};
          end else begin
            busy_r <= 1'b0;
            last_r <= 1'b0;
          end
        end
        FIRST, RUN: begin
          if (last_r) begin
            state_r       <= DONE;
            packet_done_r <= 1'b1;
            last_r        <= 1'b0;
          end else if (per_hit_s) begin
            state_r     <= RUN;
            last_r      <= bit_flag_s;
            bit_count_r <= bit_cnt_s + BIT_W'(1'b1);
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_strobe = shift_strobe_r;
  assign packet_done  = packet_done_r;
  assign busy         = busy_r;
  assign bit_count    = bit_count_r;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios plus randomized
// packets checked cycle by cycle against an enabled-cycle arithmetic model.
module tb_rx_bit_timer;

  localparam int MAXT = 1024;

  logic       clk;
  logic       n_rst;
  logic       enable_timer;
  logic       abort;
  logic [3:0] bit_period;
  logic [3:0] first_offset;
  logic [3:0] packet_bits;
  logic       shift_strobe;
  logic       packet_done;
  logic       busy;
  logic [3:0] bit_count;

  int tests;
  int fails;
  int prev_bc;

  int en_a [MAXT];
  int st_a [MAXT];
  int dn_a [MAXT];
  int bz_a [MAXT];
  int bc_a [MAXT];

  rx_bit_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .abort        (abort),
    .bit_period   (bit_period),
    .first_offset (first_offset),
    .packet_bits  (packet_bits),
    .shift_strobe (shift_strobe),
    .packet_done  (packet_done),
    .busy         (busy),
    .bit_count    (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs(input int t, input int st, input int dn, input int bz, input int bc);
    chk("shift_strobe", t, int'(shift_strobe), st);
    chk("packet_done", t, int'(packet_done), dn);
    chk("busy", t, int'(busy), bz);
    chk("bit_count", t, int'(bit_count), bc);
  endtask

  task automatic rand_cfg();
    bit_period   = 4'($urandom_range(15));
    first_offset = 4'($urandom_range(15));
    packet_bits  = 4'($urandom_range(15));
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      check_outputs(t, 0, 0, 0, prev_bc);
      n_rst        = 1'b1;
      abort        = 1'b0;
      enable_timer = 1'b0;
      rand_cfg();
    end
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset, applied at cycle kill_at
  task automatic run_packet(input int per, input int off, input int bits, input int pct,
                            input int p_lo, input int p_hi, input int kill_at, input int kill_kind);
    int per_e, off_e, bits_e, cum, k, target, last_t, end_t, win, cnt, r;
    bit killed;
    per_e  = (per == 0) ? 1 : per;
    off_e  = (off == 0) ? 1 : off;
    bits_e = (bits == 0) ? 1 : bits;
    for (int t = 0; t < MAXT; t++) begin
      r = $urandom_range(99);
      en_a[t] = (r < pct || (t >= p_lo && t <= p_hi)) ? 0 : 1;
      st_a[t] = 0; dn_a[t] = 0; bz_a[t] = 0; bc_a[t] = 0;
    end
    en_a[0] = 1;
    // strobe k lands one cycle after the enabled-cycle count reaches off + k*per
    cum = 0; k = 0; target = off_e; last_t = 0;
    for (int t = 0; t < MAXT - 2 && k < bits_e; t++) begin
      if (en_a[t] != 0) begin
        cum++;
        if (cum == target) begin
          st_a[t + 1] = 1;
          k++;
          target += per_e;
          last_t = t + 1;
        end
      end
    end
    end_t = last_t + 1;
    dn_a[end_t] = 1;
    cnt = 0;
    for (int t = 1; t <= end_t; t++) begin
      bz_a[t] = 1;
      cnt += st_a[t];
      bc_a[t] = cnt;
    end
    bc_a[0] = prev_bc;
    killed = (kill_kind != 0) && (kill_at >= 0) && (kill_at <= end_t);
    if (killed) begin
      for (int t = kill_at + 1; t < MAXT; t++) begin
        st_a[t] = 0; dn_a[t] = 0; bz_a[t] = 0; bc_a[t] = 0;
      end
      win = kill_at + 2;
      prev_bc = 0;
    end else begin
      win = end_t;
      prev_bc = bits_e;
    end
    for (int t = 0; t <= win; t++) begin
      @(negedge clk);
      check_outputs(t, st_a[t], dn_a[t], bz_a[t], bc_a[t]);
      n_rst        = 1'b1;
      abort        = 1'b0;
      enable_timer = (en_a[t] != 0);
      if (t == 0) begin
        bit_period   = 4'(per);
        first_offset = 4'(off);
        packet_bits  = 4'(bits);
      end else begin
        rand_cfg();
      end
      if (killed) begin
        if (t == kill_at || t == kill_at + 1) begin
          if (kill_kind == 1) abort = 1'b1;
          else n_rst = 1'b0;
        end
        if (t == kill_at + 1) enable_timer = 1'b1;
        if (t == kill_at + 2) enable_timer = 1'b0;
      end
    end
  endtask

  initial begin
    int per, off, bits, pct, kind, kat, r;
    tests = 0;
    fails = 0;
    prev_bc = 0;
    n_rst = 1'b0;
    abort = 1'b0;
    enable_timer = 1'b0;
    bit_period = 4'd0;
    first_offset = 4'd0;
    packet_bits = 4'd0;
    repeat (3) @(negedge clk);
    check_outputs(-1, 0, 0, 0, 0);
    n_rst = 1'b1;
    idle(2);

    // defaults, back-to-back with enable held high
    run_packet(10, 10, 9, 0, -1, -1, -1, 0);
    run_packet(10, 10, 9, 0, -1, -1, -1, 0);
    idle(3);
    // mid-bit offset, then with a two-cycle pause
    run_packet(8, 4, 3, 0, -1, -1, -1, 0);
    run_packet(8, 4, 3, 0, 6, 7, -1, 0);
    // all-zero config
    run_packet(0, 0, 0, 0, -1, -1, -1, 0);
    idle(2);
    // abort at cycle 15, reset at cycle 35, abort together with start in IDLE
    run_packet(10, 10, 9, 0, -1, -1, 15, 1);
    run_packet(10, 10, 9, 0, -1, -1, 35, 2);
    run_packet(8, 4, 3, 0, -1, -1, 0, 1);
    idle(2);

    for (int i = 0; i < 25; i++) begin
      per  = $urandom_range(15);
      off  = $urandom_range(15);
      bits = $urandom_range(15);
      pct  = $urandom_range(30);
      r    = $urandom_range(9);
      kind = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
      kat  = $urandom_range(60);
      run_packet(per, off, bits, pct, -1, -1, kat, kind);
      if ($urandom_range(1) == 1) idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
